// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle control unit: the state encoding
// (also driven out on State_o), the opcodes the decoder recognises and the
// ALUOp codes handed to the ALU control.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WB = 4'd5,
    S_MEM_WR = 4'd6,
    S_EXEC_R = 4'd7,
    S_R_WB   = 4'd8,
    S_EXEC_I = 4'd9,
    S_I_WB   = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_FAULT  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OR    = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b10;
  localparam logic [1:0] ALU_FUNCT = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting for memory in one memory state and flags the
// last allowed waiting cycle so the controller can abandon the access.
//   clk     in  clock
//   rst_n   in  synchronous active-low reset
//   clear   in  restart the count (asserted on every state change)
//   enable  in  a waiting cycle: in a memory state with no ready this cycle
//   expire  out this waiting cycle is the MEM_TIMEOUT-th one
// MEM_TIMEOUT = 0 disables expiry entirely.
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CW-1:0] count;

  // Clear wins over enable so the count starts at zero in the state entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // count holds the waiting cycles already spent, so the current one is the
  // MEM_TIMEOUT-th when count has reached MEM_TIMEOUT-1.
  assign expire = (MEM_TIMEOUT > 0) && enable && (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM of a multicycle MIPS-style datapath with memory handshake
// and bus timeout.
//   clk_i, rst_i (sync, active-low), start_i, Op_i[5:0], mem_ready_i  in
//   datapath strobes PCWrite_o .. ALUOp_o, Done_o (instruction retired),
//   Illegal_o / BusErr_o (one-cycle fault reasons), State_o[3:0]       out
// ---------------------------------------------------------------------------
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int EN_ADDI     = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int ALUOP_W     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [5:0]         Op_i,
  input  logic               mem_ready_i,
  output logic               PCWrite_o,
  output logic               PCWriteCond_o,
  output logic [1:0]         PCSource_o,
  output logic               IorD_o,
  output logic               IRWrite_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemtoReg_o,
  output logic               RegDst_o,
  output logic               RegWrite_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic               ExtOp_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               Done_o,
  output logic               Illegal_o,
  output logic               BusErr_o,
  output logic [3:0]         State_o
);

  state_t     state;
  state_t     state_next;
  logic       bus_err_q;
  logic       bus_err_next;
  logic [1:0] alu_code;
  logic       waiting;
  logic       expire;
  logic       timer_clear;
  logic       timer_enable;

  // A FAULT entered by timeout reports BusErr, any other FAULT is Illegal;
  // the flag is loaded on the edge into FAULT and drops on the way out.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      bus_err_q <= bus_err_next;
    end
  end

  assign waiting      = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timer_clear  = (state_next != state);
  assign timer_enable = waiting && !mem_ready_i;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clear (timer_clear),
    .enable(timer_enable),
    .expire(expire)
  );

  // Next state and strobes. mem_ready_i is checked before expire so a ready
  // arriving on the last allowed cycle still completes the access.
  always_comb begin
    state_next    = state;
    bus_err_next  = 1'b0;
    alu_code      = ALU_OR;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSource_o    = 2'b00;
    IorD_o        = 1'b0;
    IRWrite_o     = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ExtOp_o       = 1'b0;
    Done_o        = 1'b0;
    Illegal_o     = 1'b0;
    BusErr_o      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) state_next = S_FETCH;
      end
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        alu_code  = ALU_ADD;
        if (mem_ready_i) begin
          IRWrite_o  = 1'b1;
          PCWrite_o  = 1'b1;
          state_next = S_DECODE;
        end else if (expire) begin
          state_next   = S_FAULT;
          bus_err_next = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB_o = 2'b11;
        ExtOp_o   = 1'b1;
        alu_code  = ALU_ADD;
        case (Op_i)
          OP_RTYPE:     state_next = S_EXEC_R;
          OP_ORI:       state_next = S_EXEC_I;
          OP_ADDI:      state_next = (EN_ADDI != 0) ? S_EXEC_I : S_FAULT;
          OP_LW, OP_SW: state_next = S_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FAULT;
        endcase
      end
      S_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ExtOp_o   = 1'b1;
        alu_code  = ALU_ADD;
        if (Op_i == OP_LW)      state_next = S_MEM_RD;
        else if (Op_i == OP_SW) state_next = S_MEM_WR;
        else                    state_next = S_FAULT;
      end
      S_MEM_RD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) begin
          state_next = S_MEM_WB;
        end else if (expire) begin
          state_next   = S_FAULT;
          bus_err_next = 1'b1;
        end
      end
      S_MEM_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        Done_o     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) begin
          Done_o     = 1'b1;
          state_next = S_FETCH;
        end else if (expire) begin
          state_next   = S_FAULT;
          bus_err_next = 1'b1;
        end
      end
      S_EXEC_R: begin
        ALUSrcA_o  = 1'b1;
        alu_code   = ALU_FUNCT;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
        Done_o     = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        if ((EN_ADDI != 0) && (Op_i == OP_ADDI)) begin
          ExtOp_o  = 1'b1;
          alu_code = ALU_ADD;
        end
        state_next = S_I_WB;
      end
      S_I_WB: begin
        RegWrite_o = 1'b1;
        Done_o     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        alu_code      = ALU_SUB;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'b01;
        Done_o        = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = 2'b10;
        Done_o     = 1'b1;
        state_next = S_FETCH;
      end
      S_FAULT: begin
        Illegal_o  = !bus_err_q;
        BusErr_o   = bus_err_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ALUOp_o = ALUOP_W'(alu_code);
  assign State_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboard bench. The stimulus side turns each instruction (opcode plus
// fetch and memory latencies) into the sequence of states the controller
// must walk through, drives mem_ready_i/start_i from that sequence and
// queues the full output vector expected in each cycle. A monitor on the
// falling edge pops the queue and compares. A second instance built with
// EN_ADDI=0 shares the inputs for the addi-disabled case.
// ---------------------------------------------------------------------------
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam int T       = 4;
  localparam bit EN_ADDI = 1'b1;

  logic       clk_i       = 1'b0;
  logic       rst_i       = 1'b0;
  logic       start_i     = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic [5:0] Op_i        = 6'd0;

  logic       PCWrite_o, PCWriteCond_o, IorD_o, IRWrite_o, MemRead_o, MemWrite_o;
  logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ExtOp_o;
  logic       Done_o, Illegal_o, BusErr_o;
  logic [1:0] PCSource_o, ALUSrcB_o, ALUOp_o;
  logic [3:0] State_o;

  logic       PCWrite_b, PCWriteCond_b, IorD_b, IRWrite_b, MemRead_b, MemWrite_b;
  logic       MemtoReg_b, RegDst_b, RegWrite_b, ALUSrcA_b, ExtOp_b;
  logic       Done_b, Illegal_b, BusErr_b;
  logic [1:0] PCSource_b, ALUSrcB_b, ALUOp_b;
  logic [3:0] State_b;

  always #5 clk_i = ~clk_i;

  multicycle_control #(.EN_ADDI(1), .MEM_TIMEOUT(T), .ALUOP_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .PCSource_o(PCSource_o),
    .IorD_o(IorD_o), .IRWrite_o(IRWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ExtOp_o(ExtOp_o), .ALUOp_o(ALUOp_o),
    .Done_o(Done_o), .Illegal_o(Illegal_o), .BusErr_o(BusErr_o), .State_o(State_o)
  );

  multicycle_control #(.EN_ADDI(0), .MEM_TIMEOUT(0), .ALUOP_W(2)) dut_noaddi (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_b), .PCWriteCond_o(PCWriteCond_b), .PCSource_o(PCSource_b),
    .IorD_o(IorD_b), .IRWrite_o(IRWrite_b), .MemRead_o(MemRead_b), .MemWrite_o(MemWrite_b),
    .MemtoReg_o(MemtoReg_b), .RegDst_o(RegDst_b), .RegWrite_o(RegWrite_b),
    .ALUSrcA_o(ALUSrcA_b), .ALUSrcB_o(ALUSrcB_b), .ExtOp_o(ExtOp_b), .ALUOp_o(ALUOp_b),
    .Done_o(Done_b), .Illegal_o(Illegal_b), .BusErr_o(BusErr_b), .State_o(State_b)
  );

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       start;
    logic       bus;
  } step_t;

  typedef struct {
    logic [23:0] vec;
    int          idx;
  } exp_t;

  step_t path[$];
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    checks   = 0;
  int    failures = 0;
  int    step_cnt = 0;

  logic [3:0] b_st[5];
  logic       b_ill[5];

  // Expected outputs for one cycle, straight from the per-state output list.
  function automatic logic [23:0] model_out(logic [3:0] st, logic rdy, logic [5:0] op, logic bus);
    logic done, ill, berr, pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, ext;
    logic [1:0] pcsrc, asb, aop;
    {done, ill, berr, pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, ext} = '0;
    pcsrc = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1; asb = 2'b01; aop = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE: begin asb = 2'b11; ext = 1; aop = 2'b01; end
      S_ADDR:   begin asa = 1; asb = 2'b10; ext = 1; aop = 2'b01; end
      S_MEM_RD: begin mrd = 1; iord = 1; end
      S_MEM_WB: begin rw = 1; m2r = 1; done = 1; end
      S_MEM_WR: begin mwr = 1; iord = 1; done = rdy; end
      S_EXEC_R: begin asa = 1; aop = 2'b11; end
      S_R_WB:   begin rw = 1; rdst = 1; done = 1; end
      S_EXEC_I: begin
        asa = 1; asb = 2'b10;
        if (EN_ADDI && op == OP_ADDI) begin ext = 1; aop = 2'b01; end
      end
      S_I_WB:   begin rw = 1; done = 1; end
      S_BRANCH: begin asa = 1; aop = 2'b10; pcwc = 1; pcsrc = 2'b01; done = 1; end
      S_JUMP:   begin pcw = 1; pcsrc = 2'b10; done = 1; end
      S_FAULT:  begin ill = !bus; berr = bus; end
      default: ;
    endcase
    return {st, done, ill, berr, pcw, pcwc, pcsrc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, asb, ext, aop};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {State_o, Done_o, Illegal_o, BusErr_o, PCWrite_o, PCWriteCond_o, PCSource_o,
            IorD_o, IRWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, RegDst_o, RegWrite_o,
            ALUSrcA_o, ALUSrcB_o, ExtOp_o, ALUOp_o};
  endfunction

  task automatic check_output(input string name, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_step(input logic [3:0] st, input logic rdy, input logic start, input logic bus);
    path.push_back('{st, rdy, start, bus});
  endtask

  // A memory wait with d not-ready cycles: completes if the ready lands
  // within T cycles, otherwise T idle cycles then FAULT (bus) and IDLE.
  task automatic add_wait(input logic [3:0] st, input int d, output bit faulted);
    if (d < T) begin
      repeat (d) push_step(st, 1'b0, 1'b0, 1'b0);
      push_step(st, 1'b1, 1'b0, 1'b0);
      faulted = 1'b0;
    end else begin
      repeat (T) push_step(st, 1'b0, 1'b0, 1'b0);
      push_step(S_FAULT, 1'b0, 1'b0, 1'b1);
      push_step(S_IDLE, 1'b0, 1'b1, 1'b0);
      faulted = 1'b1;
    end
  endtask

  // One instruction starting in FETCH; every path ends leading into FETCH.
  task automatic build_path(input logic [5:0] op, input int fd, input int md);
    bit f;
    add_wait(S_FETCH, fd, f);
    if (f) return;
    push_step(S_DECODE, 1'b0, 1'b0, 1'b0);
    if (op == OP_RTYPE) begin
      push_step(S_EXEC_R, 1'b0, 1'b0, 1'b0);
      push_step(S_R_WB, 1'b0, 1'b0, 1'b0);
    end else if (op == OP_ORI || (op == OP_ADDI && EN_ADDI)) begin
      push_step(S_EXEC_I, 1'b0, 1'b0, 1'b0);
      push_step(S_I_WB, 1'b0, 1'b0, 1'b0);
    end else if (op == OP_LW) begin
      push_step(S_ADDR, 1'b0, 1'b0, 1'b0);
      add_wait(S_MEM_RD, md, f);
      if (!f) push_step(S_MEM_WB, 1'b0, 1'b0, 1'b0);
    end else if (op == OP_SW) begin
      push_step(S_ADDR, 1'b0, 1'b0, 1'b0);
      add_wait(S_MEM_WR, md, f);
    end else if (op == OP_BEQ) begin
      push_step(S_BRANCH, 1'b0, 1'b0, 1'b0);
    end else if (op == OP_J) begin
      push_step(S_JUMP, 1'b0, 1'b0, 1'b0);
    end else begin
      push_step(S_FAULT, 1'b0, 1'b0, 1'b0);
      push_step(S_IDLE, 1'b0, 1'b1, 1'b0);
    end
  endtask

  // Drives the queued path, one step per clock; the opcode is only
  // meaningful where it is sampled, so elsewhere it is scrambled.
  task automatic apply_stimulus(input logic [5:0] op, input bit chk_b);
    for (int i = 0; i < path.size(); i++) begin
      if (path[i].st == S_DECODE || path[i].st == S_ADDR || path[i].st == S_EXEC_I) Op_i = op;
      else Op_i = 6'($urandom);
      mem_ready_i = path[i].rdy;
      start_i     = path[i].start;
      exp_q.push_back('{model_out(path[i].st, path[i].rdy, op, path[i].bus), step_cnt});
      step_cnt++;
      if (chk_b && i < 5)
        check_output($sformatf("noaddi_step%0d", i), {18'b0, State_b, Illegal_b, BusErr_b},
                     {18'b0, b_st[i], b_ill[i], 1'b0});
      @(posedge clk_i); #1;
    end
    path.delete();
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output($sformatf("step%0d_state%0d", mon_e.idx, mon_e.vec[23:20]), dut_vec(), mon_e.vec);
    end
  end

  initial begin
    logic [5:0] op_tab[8];
    logic [5:0] op;
    int fd, md;
    op_tab = '{OP_RTYPE, OP_ORI, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, 6'b111111};

    rst_i = 1'b0; start_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_output("reset_idle", dut_vec(), 24'h0);
    rst_i = 1'b1; start_i = 1'b0;
    @(posedge clk_i); #1;
    check_output("idle_without_start", dut_vec(), 24'h0);

    push_step(S_IDLE, 1'b0, 1'b1, 1'b0);
    build_path(OP_RTYPE, 0, 0);    apply_stimulus(OP_RTYPE, 1'b0);
    build_path(OP_LW, 0, 3);       apply_stimulus(OP_LW, 1'b0);
    build_path(OP_SW, 1, T - 1);   apply_stimulus(OP_SW, 1'b0);
    build_path(OP_SW, 0, T);       apply_stimulus(OP_SW, 1'b0);
    build_path(OP_LW, T, 0);       apply_stimulus(OP_LW, 1'b0);
    build_path(6'b111111, 0, 0);   apply_stimulus(6'b111111, 1'b0);
    build_path(OP_ORI, 2, 0);      apply_stimulus(OP_ORI, 1'b0);
    build_path(OP_ADDI, 0, 0);     apply_stimulus(OP_ADDI, 1'b0);
    build_path(OP_BEQ, 0, 0);      apply_stimulus(OP_BEQ, 1'b0);
    build_path(OP_J, 1, 0);        apply_stimulus(OP_J, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op = op_tab[$urandom_range(0, 7)];
      if (op == 6'b111111) op = 6'($urandom);
      fd = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
      md = ($urandom_range(0, 5) == 0) ? T + 1 : $urandom_range(0, T - 1);
      build_path(op, fd, md);
      apply_stimulus(op, 1'b0);
    end

    // Reset in the middle of a store that is still waiting for memory.
    push_step(S_FETCH, 1'b1, 1'b0, 1'b0);
    push_step(S_DECODE, 1'b0, 1'b0, 1'b0);
    push_step(S_ADDR, 1'b0, 1'b0, 1'b0);
    push_step(S_MEM_WR, 1'b0, 1'b0, 1'b0);
    apply_stimulus(OP_SW, 1'b0);
    rst_i = 1'b0; mem_ready_i = 1'b0; Op_i = OP_SW;
    exp_q.push_back('{model_out(S_MEM_WR, 1'b0, OP_SW, 1'b0), step_cnt});
    step_cnt++;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    check_output("reset_mid_write", dut_vec(), 24'h0);
    exp_q.push_back('{model_out(S_IDLE, 1'b0, OP_SW, 1'b0), step_cnt});
    step_cnt++;
    @(posedge clk_i); #1;

    // addi on both instances: decoded on one, illegal on the other.
    b_st  = '{S_IDLE, S_FETCH, S_DECODE, S_FAULT, S_IDLE};
    b_ill = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    push_step(S_IDLE, 1'b0, 1'b1, 1'b0);
    build_path(OP_ADDI, 0, 0);
    apply_stimulus(OP_ADDI, 1'b1);

    start_i = 1'b0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_output("scoreboard_drained", 24'(exp_q.size()), 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL provide parameter EN_ADDI, default 1: 1 decodes addi (6'b001000), 0 treats it as illegal.
REQ-002 The block SHALL provide parameter MEM_TIMEOUT, default 15: maximum mem_ready_i wait cycles per memory state; 0 disables the timeout.
REQ-003 The block SHALL provide parameter ALUOP_W, default 2: ALUOp width, minimum 2; codes zero-extended.
REQ-004 The ports SHALL be: clk_i  in  1  clock; rst_i  in  1  reset; start_i  in  1  leave IDLE; Op_i  in  6  opcode from IR; mem_ready_i  in  1  memory access complete.
REQ-005 The block SHALL have one clock; reset is synchronous and active-low (clk_i, rst_i).
REQ-006 Outputs SHALL be: PCWrite_o 1, PCWriteCond_o 1, PCSource_o 2, IorD_o 1, IRWrite_o 1, MemRead_o 1, MemWrite_o 1, MemtoReg_o 1, RegDst_o 1, RegWrite_o 1, ALUSrcA_o 1, ALUSrcB_o 2, ExtOp_o 1, ALUOp_o ALUOP_W, Done_o 1 (instruction retired), Illegal_o 1, BusErr_o 1, State_o 4.

Function
REQ-007 ALUOp codes SHALL be 00 OR, 01 ADD, 10 SUB, 11 R-type funct decode.
REQ-008 States SHALL be IDLE, FETCH, DECODE, ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, FAULT; one transition per clk_i edge.
REQ-009 IDLE: all strobes low; to FETCH when start_i=1.
REQ-010 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00; IRWrite and PCWrite high only in the cycle mem_ready_i=1, which moves to DECODE; otherwise remain.
REQ-011 DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=ADD; next by Op_i: 000000 EXEC_R, 001101 EXEC_I, 001000 EXEC_I (EN_ADDI=1), 100011/101011 ADDR, 000100 BRANCH, 000010 JUMP, else FAULT.
REQ-012 ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=ADD; to MEM_RD (lw) or MEM_WR (sw).
REQ-013 MEM_RD: MemRead=1, IorD=1; to MEM_WB on mem_ready_i. MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, Done=1; to FETCH.
REQ-014 MEM_WR: MemWrite=1, IorD=1; on mem_ready_i Done=1 and to FETCH.
REQ-015 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=11; to R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0, Done=1; to FETCH.
REQ-016 EXEC_I: ALUSrcA=1, ALUSrcB=10; ori ExtOp=0/ALUOp=OR, addi ExtOp=1/ALUOp=ADD; to I_WB. I_WB: RegWrite=1, RegDst=0, MemtoReg=0, Done=1; to FETCH.
REQ-017 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01, Done=1; to FETCH.
REQ-018 JUMP: PCWrite=1, PCSource=10, Done=1; to FETCH.
REQ-019 Wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR, increment each waiting cycle; at MEM_TIMEOUT cycles without mem_ready_i go to FAULT with BusErr latched.
REQ-020 FAULT: Illegal_o or BusErr_o high for exactly one cycle, all strobes low; to IDLE.
REQ-021 mem_ready_i coinciding with timeout expiry SHALL count as completion.
REQ-022 Op_i is sampled only in DECODE, ADDR, EXEC_I; outputs not listed for a state SHALL be 0.
REQ-023 State_o SHALL equal the encoded current state.

Reset
REQ-024 rst_i=0 at a clock edge SHALL force IDLE, clear the wait counter and flags, in any state including mid-memory access; all outputs 0, State_o=IDLE.

Structure
REQ-025 Package ctrl_pkg SHALL hold state encoding, opcode constants and ALUOp codes.
REQ-026 Sub-module mem_wait_timer (clear, enable, expire output, width clog2(MEM_TIMEOUT+1)) SHALL implement REQ-019.

Verification
REQ-027 Reset, start_i=1, Op_i=000000, ready immediate -> IDLE,FETCH,DECODE,EXEC_R,R_WB; Done at cycle 5, RegDst=1.
REQ-028 lw with ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles, MemRead=IorD=1, then MEM_WB MemtoReg=1.
REQ-029 Op_i=001000 with EN_ADDI=0 -> FAULT, Illegal_o one cycle, IDLE; with EN_ADDI=1 -> I_WB, ExtOp=1, ALUOp=01.
REQ-030 MEM_TIMEOUT=4, mem_ready_i held 0 in MEM_WR -> FAULT after 4 cycles, BusErr_o one pulse, MemWrite drops.
REQ-031 rst_i=0 during MEM_WR with MemWrite=1 -> next cycle IDLE, all outputs 0.
